// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single fixed-latency memory.
// Round-robin on ties; misaligned data accesses are answered locally with an error.
module mem_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        m_en,
    output logic [31:0] m_addr,
    output logic [2:0]  m_we,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [1:0] LAST_CNT = 2'(MEM_LAT - 1);

    state_t      state_reg, state_next;
    logic [1:0]  cnt_reg;
    logic        fetch_last_reg;
    logic        port_reg;
    logic [2:0]  we_reg;
    logic [31:0] addr_reg, wdata_reg;
    logic        i_rvalid_reg, d_rvalid_reg, d_err_reg;
    logic [31:0] i_rdata_reg, d_rdata_reg;
    logic        d_misaligned, last_busy;

    assign d_misaligned = (d_we[0] && (d_addr[1:0] != 2'b00)) || (d_we[1] && d_addr[0]);
    assign last_busy    = (state_reg == BUSY) && (cnt_reg == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        m_en       = 1'b0;
        m_we       = 3'b000;
        case (state_reg)
            IDLE: begin
                // Grants are gated by rst so nothing is offered while reset is held.
                if (!rst) begin
                    if (d_req && (!i_req || fetch_last_reg)) d_gnt = 1'b1;
                    else if (i_req)                          i_gnt = 1'b1;
                end
                if (i_gnt || (d_gnt && !d_misaligned)) state_next = BUSY;
            end
            BUSY: begin
                m_en = 1'b1;
                if (cnt_reg == 2'd0) m_we = we_reg;
                if (last_busy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg        <= 2'd0;
            fetch_last_reg <= 1'b1;
            port_reg       <= 1'b0;
            we_reg         <= 3'b000;
            addr_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
            i_rvalid_reg   <= 1'b0;
            d_rvalid_reg   <= 1'b0;
            d_err_reg      <= 1'b0;
            i_rdata_reg    <= 32'd0;
            d_rdata_reg    <= 32'd0;
        end else begin
            i_rvalid_reg <= 1'b0;
            d_rvalid_reg <= 1'b0;
            d_err_reg    <= 1'b0;
            if (state_reg == BUSY) cnt_reg <= cnt_reg + 2'd1;
            else                   cnt_reg <= 2'd0;
            if (i_gnt || d_gnt) fetch_last_reg <= i_gnt;
            if (i_gnt) begin
                port_reg <= 1'b0;
                addr_reg <= i_addr;
                we_reg   <= 3'b000;
            end
            if (d_gnt) begin
                // A misaligned access never reaches memory, so m_addr/m_wdata keep their values.
                if (d_misaligned) begin
                    d_rvalid_reg <= 1'b1;
                    d_err_reg    <= 1'b1;
                    d_rdata_reg  <= 32'd0;
                end else begin
                    port_reg  <= 1'b1;
                    addr_reg  <= d_addr;
                    we_reg    <= d_we;
                    wdata_reg <= d_wdata;
                end
            end
            if (last_busy) begin
                if (port_reg) begin
                    d_rvalid_reg <= 1'b1;
                    d_rdata_reg  <= m_rdata;
                end else begin
                    i_rvalid_reg <= 1'b1;
                    i_rdata_reg  <= m_rdata;
                end
            end
        end
    end

    assign m_addr   = addr_reg;
    assign m_wdata  = wdata_reg;
    assign i_rvalid = i_rvalid_reg;
    assign i_rdata  = i_rdata_reg;
    assign d_rvalid = d_rvalid_reg;
    assign d_rdata  = d_rdata_reg;
    assign d_err    = d_err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances with MEM_LAT = 1, 2, 3 share
// the same stimulus; each step checks the instance whose latency it targets.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
    logic [2:0]  d_we = '0;

    logic [3:1]  i_gnt, i_rvalid, d_gnt, d_rvalid, d_err, m_en;
    logic [31:0] i_rdata [1:3];
    logic [31:0] d_rdata [1:3];
    logic [31:0] m_addr  [1:3];
    logic [31:0] m_wdata [1:3];
    logic [2:0]  m_we    [1:3];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    for (genvar gi = 1; gi <= 3; gi++) begin : g_dut
        mem_arbiter #(.MEM_LAT(gi)) dut (
            .clk(clk), .rst(rst),
            .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt[gi]),
            .i_rvalid(i_rvalid[gi]), .i_rdata(i_rdata[gi]),
            .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
            .d_gnt(d_gnt[gi]), .d_rvalid(d_rvalid[gi]), .d_rdata(d_rdata[gi]),
            .d_err(d_err[gi]),
            .m_en(m_en[gi]), .m_addr(m_addr[gi]), .m_we(m_we[gi]),
            .m_wdata(m_wdata[gi]), .m_rdata(m_rdata)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 3'b000;
        tick; tick;
        rst = 1'b0;
    endtask

    initial begin
        logic seen;
        logic found;

        // Reset state, with both requests raised while reset is held.
        i_req = 1'b1; d_req = 1'b1;
        tick; tick;
        chk("rst_gnt", {29'd0, i_gnt[1], d_gnt[1], m_en[1]}, 32'd0);
        chk("rst_valid", {29'd0, i_rvalid[1], d_rvalid[1], d_err[1]}, 32'd0);
        chk("rst_m_we", {29'd0, m_we[1]}, 32'd0);
        chk("rst_m_addr", m_addr[1], 32'd0);
        chk("rst_rdata", i_rdata[1] | d_rdata[1], 32'd0);

        // Single fetch, MEM_LAT=1.
        do_reset;
        i_req = 1'b1; i_addr = 32'h40; #1;
        chk("f_gnt", {30'd0, i_gnt[1], d_gnt[1]}, 32'h2);
        tick; i_req = 1'b0; m_rdata = 32'h13; #1;
        chk("f_m_en", {31'd0, m_en[1]}, 32'd1);
        chk("f_m_addr", m_addr[1], 32'h40);
        chk("f_rvalid_early", {31'd0, i_rvalid[1]}, 32'd0);
        tick;
        chk("f_rvalid", {30'd0, i_rvalid[1], d_rvalid[1]}, 32'h2);
        chk("f_rdata", i_rdata[1], 32'h13);
        m_rdata = 32'hDEAD; tick;
        chk("f_rvalid_pulse", {31'd0, i_rvalid[1]}, 32'd0);
        chk("f_rdata_hold", i_rdata[1], 32'h13);
        chk("f_idle_m_en", {31'd0, m_en[1]}, 32'd0);
        chk("f_addr_hold", m_addr[1], 32'h40);

        // Both requesting from reset release: d, i, d, i.
        do_reset;
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h100; d_addr = 32'h200; #1;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            for (int c = 0; c < 6 && !found; c++) begin
                if (i_gnt[1] || d_gnt[1]) found = 1'b1;
                else tick;
            end
            chk($sformatf("rr_found_%0d", k), {31'd0, found}, 32'd1);
            chk($sformatf("rr_grant_%0d", k), {30'd0, i_gnt[1], d_gnt[1]},
                (k % 2 == 0) ? 32'h1 : 32'h2);
            tick;
        end
        i_req = 1'b0; d_req = 1'b0;

        // Byte write: m_we for one cycle only, completion after BUSY.
        do_reset;
        d_req = 1'b1; d_we = 3'b100; d_addr = 32'h10000003; d_wdata = 32'hAB; #1;
        chk("w_gnt", {31'd0, d_gnt[1]}, 32'd1);
        tick; d_req = 1'b0; d_we = 3'b000; d_wdata = 32'h0; m_rdata = 32'h5555AAAA; #1;
        chk("w_m_we1", {29'd0, m_we[1]}, 32'h4);
        chk("w_m_we3", {29'd0, m_we[3]}, 32'h4);
        chk("w_m_wdata", m_wdata[1], 32'hAB);
        tick;
        chk("w_done", {30'd0, d_rvalid[1], d_err[1]}, 32'h2);
        chk("w_rdata", d_rdata[1], 32'h5555AAAA);
        chk("w_m_we1_off", {28'd0, m_en[1], m_we[1]}, 32'h0);
        chk("w_m_we3_off", {28'd0, m_en[3], m_we[3]}, 32'h8);
        tick; tick;
        chk("w_done3", {30'd0, d_rvalid[3], d_err[3]}, 32'h2);

        // Misaligned word, misaligned half, then aligned half.
        d_req = 1'b1; d_we = 3'b001; d_addr = 32'h10000002; #1;
        chk("mw_gnt", {31'd0, d_gnt[1]}, 32'd1);
        tick; d_we = 3'b010; d_addr = 32'h10000001; #1;
        chk("mw_no_mem", {28'd0, m_en[1], m_we[1]}, 32'h0);
        chk("mw_err", {30'd0, d_rvalid[1], d_err[1]}, 32'h3);
        chk("mw_rdata", d_rdata[1], 32'h0);
        chk("mh_gnt", {31'd0, d_gnt[1]}, 32'd1);
        tick; d_req = 1'b0; #1;
        chk("mh_err", {30'd0, d_rvalid[1], d_err[1]}, 32'h3);
        chk("mh_addr_hold", m_addr[1], 32'h10000003);
        tick;
        chk("mh_err_clear", {30'd0, d_rvalid[1], d_err[1]}, 32'h0);
        d_req = 1'b1; d_addr = 32'h10000002; #1;
        chk("ah_gnt", {31'd0, d_gnt[1]}, 32'd1);
        tick; d_req = 1'b0; #1;
        chk("ah_mem", {28'd0, m_en[1], m_we[1]}, 32'hA);
        tick;
        chk("ah_done", {30'd0, d_rvalid[1], d_err[1]}, 32'h2);

        // MEM_LAT=3: reset during the second BUSY cycle.
        do_reset;
        d_we = 3'b000; i_req = 1'b1; i_addr = 32'h80; #1;
        chk("ar_gnt", {31'd0, i_gnt[3]}, 32'd1);
        tick; i_req = 1'b0;
        tick;
        chk("ar_busy", {31'd0, m_en[3]}, 32'd1);
        #2 rst = 1'b1; #1;
        chk("ar_async", {28'd0, m_en[3], m_we[3]}, 32'h0);
        tick; rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            seen = seen | i_rvalid[3] | d_rvalid[3];
            tick;
        end
        chk("ar_no_rvalid", {31'd0, seen}, 32'd0);
        i_req = 1'b1; i_addr = 32'h84; #1;
        chk("ar_regnt", {31'd0, i_gnt[3]}, 32'd1);
        tick; i_req = 1'b0; m_rdata = 32'h99; #1;
        chk("ar_m_addr", m_addr[3], 32'h84);
        tick; tick; tick;
        chk("ar_rvalid", {31'd0, i_rvalid[3]}, 32'd1);
        chk("ar_rdata", i_rdata[3], 32'h99);

        // MEM_LAT=2: back-to-back data reads.
        do_reset;
        d_req = 1'b1; d_we = 3'b000; d_addr = 32'h100; #1;
        chk("bb_gnt1", {31'd0, d_gnt[2]}, 32'd1);
        tick; d_addr = 32'h104; m_rdata = 32'h77; #1;
        chk("bb_wait1", {31'd0, d_gnt[2]}, 32'd0);
        tick;
        chk("bb_wait2", {31'd0, d_gnt[2]}, 32'd0);
        tick;
        chk("bb_gnt2", {30'd0, d_gnt[2], d_rvalid[2]}, 32'h3);
        chk("bb_rdata", d_rdata[2], 32'h77);
        tick; d_req = 1'b0; #1;
        chk("bb_addr2", m_addr[2], 32'h104);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
